// File: rtl/wb_drain_if.sv
// Upstream/array/memory-facing signal bundle of the write-back drain controller.
interface wb_drain_if #(
    parameter int width      = 128,
    parameter int addr_width = 16
);
    logic [width-1:0]      data0;
    logic [width-1:0]      data1;
    logic [width-1:0]      data2;
    logic [width-1:0]      data3;
    logic                  alloc_valid;
    logic [1:0]            alloc_index;
    logic [addr_width-1:0] alloc_addr;
    logic                  alloc_ready;
    logic [addr_width-1:0] lookup_addr;
    logic                  lookup_hit;
    logic [1:0]            lookup_index;
    logic [addr_width-1:0] pmem_address;
    logic [width-1:0]      pmem_wdata;
    logic                  pmem_write;
    logic                  pmem_resp;
    logic                  full;
    logic                  empty;
    logic                  flush_req;
    logic                  flush_done;

    modport slave (
        input  data0, data1, data2, data3,
        input  alloc_valid, alloc_index, alloc_addr,
        input  lookup_addr, pmem_resp, flush_req,
        output alloc_ready, lookup_hit, lookup_index,
        output pmem_address, pmem_wdata, pmem_write,
        output full, empty, flush_done
    );

    modport master (
        output data0, data1, data2, data3,
        output alloc_valid, alloc_index, alloc_addr,
        output lookup_addr, pmem_resp, flush_req,
        input  alloc_ready, lookup_hit, lookup_index,
        input  pmem_address, pmem_wdata, pmem_write,
        input  full, empty, flush_done
    );
endinterface

// File: rtl/wb_drain.sv
// Write-back drain: tracks dirty evicted lines in the 4-entry array and writes
// them to physical memory one at a time, round-robin, over pmem_write/pmem_resp.
module wb_drain #(
    parameter int width      = 128,
    parameter int addr_width = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_drain_if.slave   bus
);
    localparam int TAG_W = addr_width - 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pending_q, pending_d;
    logic [TAG_W-1:0] addr_q [4];
    logic [TAG_W-1:0] addr_d [4];
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       rr_q, rr_d;

    logic             alloc_ok;
    logic             alloc_ready;
    logic             hit;
    logic [1:0]       hit_idx;
    logic [width-1:0] wdata;
    logic             unused_ok;

    // First pending entry at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx]) rr_pick = idx;
        end
    endfunction

    assign alloc_ready = !(state_q == WRITE && bus.alloc_index == sel_q);
    assign alloc_ok    = bus.alloc_valid && alloc_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    sel_d   = rr_pick(pending_q, rr_q);
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.pmem_resp) begin
                    pending_d[sel_q] = 1'b0;
                    rr_d             = sel_q + 2'd1;
                    state_d          = IDLE;
                end
            end
        endcase
        // An accepted alloc never targets the in-flight entry, so it cannot
        // collide with the clear above.
        if (alloc_ok) begin
            pending_d[bus.alloc_index] = 1'b1;
            addr_d[bus.alloc_index]    = bus.alloc_addr[addr_width-1:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            sel_q     <= 2'd0;
            rr_q      <= 2'd0;
            for (int i = 0; i < 4; i++) addr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
        end
    end

    always_comb begin
        wdata = bus.data0;
        case (sel_q)
            2'd0: wdata = bus.data0;
            2'd1: wdata = bus.data1;
            2'd2: wdata = bus.data2;
            2'd3: wdata = bus.data3;
        endcase
    end

    // Descending scan so the lowest matching index is the one reported.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i] && addr_q[i] == bus.lookup_addr[addr_width-1:4]) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    assign bus.alloc_ready  = alloc_ready;
    assign bus.lookup_hit   = hit;
    assign bus.lookup_index = hit_idx;
    assign bus.pmem_address = {addr_q[sel_q], 4'b0000};
    assign bus.pmem_wdata   = wdata;
    assign bus.pmem_write   = (state_q == WRITE);
    assign bus.full         = &pending_q;
    assign bus.empty        = (pending_q == 4'b0000) && (state_q == IDLE);
    assign bus.flush_done   = (pending_q == 4'b0000) && (state_q == IDLE);

    // flush_req only stalls upstream; line-offset bits carry no tag information.
    assign unused_ok = ^{bus.flush_req, bus.alloc_addr[3:0], bus.lookup_addr[3:0]};
endmodule

// File: tb/tb_wb_drain.sv
// Bench for wb_drain: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model.
module tb_wb_drain;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    wb_drain_if #(.width(128), .addr_width(16)) bus ();

    wb_drain #(.width(128), .addr_width(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: set of pending entries with tags, plus the entry being written.
    bit         m_pend [4] = '{0, 0, 0, 0};
    logic [11:0] m_addr [4] = '{12'h0, 12'h0, 12'h0, 12'h0};
    bit         m_busy = 0;
    int         m_sel  = 0;
    int         m_rr   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] dsel(input int s);
        case (s)
            0:       return bus.data0;
            1:       return bus.data1;
            2:       return bus.data2;
            default: return bus.data3;
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                m_addr[i] = '0;
            end
            m_busy = 0; m_sel = 0; m_rr = 0;
        end else begin : model_step
            bit acc;
            bit found;
            acc = bus.alloc_valid && !(m_busy && int'(bus.alloc_index) == m_sel);
            if (m_busy) begin
                if (bus.pmem_resp) begin
                    m_pend[m_sel] = 0;
                    m_rr   = (m_sel + 1) % 4;
                    m_busy = 0;
                end
            end else begin
                found = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && m_pend[(m_rr + k) % 4]) begin
                        m_sel  = (m_rr + k) % 4;
                        m_busy = 1;
                        found  = 1;
                    end
                end
            end
            if (acc) begin
                m_pend[bus.alloc_index] = 1;
                m_addr[bus.alloc_index] = bus.alloc_addr[15:4];
            end
        end
    end

    initial forever begin
        @(negedge clk);
        begin : compare
            logic       exp_hit;
            logic [1:0] exp_idx;
            bit         anyp;
            bit         allp;
            exp_hit = 0; exp_idx = 0; anyp = 0; allp = 1;
            for (int i = 3; i >= 0; i--) begin
                if (m_pend[i] && m_addr[i] == bus.lookup_addr[15:4]) begin
                    exp_hit = 1;
                    exp_idx = 2'(i);
                end
                anyp = anyp | m_pend[i];
                allp = allp & m_pend[i];
            end
            chk("pmem_write", bus.pmem_write, m_busy);
            chk("alloc_ready", bus.alloc_ready, !(m_busy && int'(bus.alloc_index) == m_sel));
            chk("full", bus.full, allp);
            chk("empty", bus.empty, !anyp && !m_busy);
            chk("flush_done", bus.flush_done, !anyp && !m_busy);
            chk("lookup_hit", bus.lookup_hit, exp_hit);
            chk("lookup_index", bus.lookup_index, exp_idx);
            if (m_busy) begin
                chk("pmem_address", bus.pmem_address, {m_addr[m_sel], 4'h0});
                chk("pmem_wdata", bus.pmem_wdata, dsel(m_sel));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [1:0] idx, input logic [15:0] a);
        bus.alloc_valid = 1'b1;
        bus.alloc_index = idx;
        bus.alloc_addr  = a;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic wait_write(input string name);
        int n = 0;
        while (!bus.pmem_write && n < 20) begin
            tick();
            n++;
        end
        if (!bus.pmem_write) begin
            total++;
            bad++;
            $display("FAIL %s: pmem_write timeout got 0 expected 1", name);
        end
    endtask

    task automatic resp();
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [15:0] order [3];
    logic [15:0] pool  [4];

    initial begin
        rst_n           = 1'b0;
        bus.data0       = {16{8'h10}};
        bus.data1       = {16{8'h21}};
        bus.data2       = {16{8'h32}};
        bus.data3       = {16{8'h43}};
        bus.alloc_valid = 1'b0;
        bus.alloc_index = 2'd0;
        bus.alloc_addr  = 16'h0;
        bus.lookup_addr = 16'h0;
        bus.pmem_resp   = 1'b0;
        bus.flush_req   = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_write", bus.pmem_write, 1'b0);
        chk("rst_ready", bus.alloc_ready, 1'b1);
        chk("rst_flush_done", bus.flush_done, 1'b1);
        chk("rst_hit", bus.lookup_hit, 1'b0);

        // Single line with stalled acknowledge
        bus.data2 = {16{8'hA5}};
        alloc(2'd2, 16'h1234);
        chk("single_not_yet", bus.pmem_write, 1'b0);
        tick();
        chk("single_write", bus.pmem_write, 1'b1);
        chk("single_addr", bus.pmem_address, 16'h1230);
        chk("single_wdata", bus.pmem_wdata, {16{8'hA5}});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_stall", bus.pmem_write, 1'b1);
        end
        resp();
        chk("single_empty", bus.empty, 1'b1);
        chk("single_write_low", bus.pmem_write, 1'b0);

        // Round-robin drain order 0,1,3
        alloc(2'd0, 16'h1000);
        alloc(2'd1, 16'h1110);
        alloc(2'd3, 16'h1330);
        for (int i = 0; i < 3; i++) begin
            wait_write("rr_wait");
            order[i] = bus.pmem_address;
            tick();
            tick();
            resp();
            chk("rr_gap", bus.pmem_write, 1'b0);
        end
        chk("rr_first", order[0], 16'h1000);
        chk("rr_second", order[1], 16'h1110);
        chk("rr_third", order[2], 16'h1330);

        // In-flight protection
        alloc(2'd1, 16'h5550);
        wait_write("inflight_wait");
        chk("inflight_addr", bus.pmem_address, 16'h5550);
        bus.lookup_addr = 16'h9990;
        bus.alloc_valid = 1'b1;
        bus.alloc_index = 2'd1;
        bus.alloc_addr  = 16'h9990;
        #1;
        chk("inflight_reject", bus.alloc_ready, 1'b0);
        tick();
        bus.alloc_valid = 1'b0;
        chk("inflight_no_overwrite", bus.lookup_hit, 1'b0);
        bus.alloc_valid = 1'b1;
        bus.alloc_index = 2'd0;
        bus.alloc_addr  = 16'h6660;
        bus.pmem_resp   = 1'b1;
        #1;
        chk("inflight_accept", bus.alloc_ready, 1'b1);
        tick();
        bus.alloc_valid = 1'b0;
        bus.pmem_resp   = 1'b0;
        wait_write("inflight_next");
        chk("inflight_next_addr", bus.pmem_address, 16'h6660);
        resp();

        // Full and lookup priority
        do_reset();
        alloc(2'd0, 16'h1000);
        alloc(2'd1, 16'h2230);
        alloc(2'd2, 16'h3000);
        alloc(2'd3, 16'h2230);
        chk("full_set", bus.full, 1'b1);
        bus.lookup_addr = 16'h2238;
        #1;
        chk("lookup_hit", bus.lookup_hit, 1'b1);
        chk("lookup_idx1", bus.lookup_index, 2'd1);
        wait_write("full_w0");
        resp();
        wait_write("full_w1");
        chk("lookup_inflight", bus.lookup_index, 2'd1);
        resp();
        chk("lookup_hit_after", bus.lookup_hit, 1'b1);
        chk("lookup_idx3", bus.lookup_index, 2'd3);
        wait_write("full_w2");
        resp();
        wait_write("full_w3");
        resp();

        // Flush with three pending lines
        alloc(2'd0, 16'h4000);
        alloc(2'd1, 16'h4010);
        alloc(2'd2, 16'h4020);
        bus.flush_req = 1'b1;
        chk("flush_busy", bus.flush_done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_write("flush_wait");
            chk("flush_pending", bus.flush_done, 1'b0);
            resp();
        end
        chk("flush_done", bus.flush_done, 1'b1);
        bus.flush_req = 1'b0;

        // Asynchronous reset during WRITE with entries 0 and 1 pending
        alloc(2'd0, 16'hA000);
        alloc(2'd1, 16'hB000);
        wait_write("reset_wait");
        bus.lookup_addr = 16'hA000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_write", bus.pmem_write, 1'b0);
        chk("areset_empty", bus.empty, 1'b1);
        chk("areset_full", bus.full, 1'b0);
        chk("areset_hit", bus.lookup_hit, 1'b0);
        tick();
        rst_n = 1'b1;

        // Random traffic
        pool[0] = 16'h2230;
        pool[1] = 16'h4450;
        pool[2] = 16'h77F0;
        for (int c = 0; c < 3000; c++) begin
            pool[3]         = 16'($urandom);
            bus.alloc_valid = ($urandom_range(0, 2) == 0);
            bus.alloc_index = 2'($urandom_range(0, 3));
            bus.alloc_addr  = pool[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
            bus.lookup_addr = pool[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
            bus.pmem_resp   = bus.pmem_write ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 9) == 0);
            bus.flush_req   = $urandom_range(0, 1) == 1;
            bus.data0       = {$urandom, $urandom, $urandom, $urandom};
            bus.data1       = {$urandom, $urandom, $urandom, $urandom};
            bus.data2       = {$urandom, $urandom, $urandom, $urandom};
            bus.data3       = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        bus.alloc_valid = 1'b0;
        bus.pmem_resp   = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
